// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle controller: instruction fields, ALU flags and
// memory handshake in, datapath strobes and selects out.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       lt;
  logic       mem_ready;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       PCWrite;
  logic       IRWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic       MemtoReg;
  logic       IorD;
  logic       illegal;
  logic       timeout;
  logic [3:0] state;

  modport master (
    input  opcode, funct3, zero, lt, mem_ready,
    output ALUOp, ALUSrcA, ALUSrcB, PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
           MemtoReg, IorD, illegal, timeout, state
  );

  modport slave (
    output opcode, funct3, zero, lt, mem_ready,
    input  ALUOp, ALUSrcA, ALUSrcB, PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
           MemtoReg, IorD, illegal, timeout, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style main controller FSM (fetch/decode/execute/memory/writeback).
// Define MULTICYCLE_MEM_WAIT_EN to stall memory states on mem_ready with a timeout counter.
module multicycle_control #(
  parameter int unsigned MAX_WAIT = 15
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MULTICYCLE_MEM_WAIT_EN
  localparam logic [3:0] WaitLast = 4'(MAX_WAIT - 1);

  logic [3:0] wait_q, wait_d;
  logic       timeout_q, timeout_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign bus.timeout      = 1'b0;
`endif

  assign bus.state = state_q;

  always_comb begin
    state_d      = state_q;
    bus.ALUOp    = 2'b00;
    bus.ALUSrcA  = 2'b00;
    bus.ALUSrcB  = 2'b00;
    bus.PCWrite  = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.IorD     = 1'b0;
    bus.illegal  = 1'b0;

    case (state_q)
      StFetch: begin
        bus.MemRead = 1'b1;
        bus.IRWrite = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.PCWrite = 1'b1;
        state_d     = StDecode;
      end
      StDecode: begin
        // ALU precomputes the branch target from oldPC + imm
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b10;
        case (bus.opcode)
          OpLoad, OpStore: state_d = StMemAddr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          default: begin
            bus.illegal = 1'b1;
            state_d     = StFetch;
          end
        endcase
      end
      StMemAddr: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        state_d     = (bus.opcode == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        state_d     = StMemWb;
      end
      StMemWb: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        state_d      = StFetch;
      end
      StMemWrite: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        state_d      = StFetch;
      end
      StExecR: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUOp   = 2'b10;
        state_d     = StAluWb;
      end
      StExecI: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.ALUOp   = 2'b10;
        state_d     = StAluWb;
      end
      StAluWb: begin
        bus.RegWrite = 1'b1;
        state_d      = StFetch;
      end
      StBranch: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUOp   = 2'b01;
        case (bus.funct3)
          3'b000:  bus.PCWrite = bus.zero;
          3'b100:  bus.PCWrite = bus.lt;
          default: bus.PCWrite = 1'b0;
        endcase
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase

`ifdef MULTICYCLE_MEM_WAIT_EN
    wait_d    = '0;
    timeout_d = timeout_q;
    if ((state_q inside {StFetch, StMemRead, StMemWrite}) && !bus.mem_ready) begin
      // Hold the state; only the commit strobes wait for the ready cycle
      state_d     = state_q;
      bus.IRWrite = 1'b0;
      bus.PCWrite = 1'b0;
      if (wait_q == WaitLast) begin
        timeout_d = 1'b1;
        state_d   = StFetch;
      end else begin
        wait_d = wait_q + 4'd1;
      end
    end
`endif

    if (reset) begin
      bus.IRWrite = 1'b0;
      bus.PCWrite = 1'b0;
      bus.MemRead = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues hand-derived per-cycle output
// vectors, a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  // {state, ALUOp, ALUSrcA, ALUSrcB, PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
  //  MemtoReg, IorD, illegal, timeout}
  localparam logic [18:0] ResetVec = {4'd0, 2'b00, 2'b00, 2'b01, 9'b0};

  typedef struct {
    logic [18:0] v;
    string       nm;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic to_exp;
  exp_t exp_q[$];

  multicycle_control_if bus_if ();

  multicycle_control #(.MAX_WAIT(15)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] ev(input logic [3:0] st, input logic pcw, input logic ill,
                                     input logic to);
    logic [1:0] op, a, b;
    logic pcw_o, irw, mr, mw, rw, m2r, iord;
    op = 2'b00; a = 2'b00; b = 2'b00;
    pcw_o = 1'b0; irw = 1'b0; mr = 1'b0; mw = 1'b0; rw = 1'b0; m2r = 1'b0; iord = 1'b0;
    case (st)
      4'd0: begin b = 2'b01; pcw_o = pcw; irw = pcw; mr = 1'b1; end
      4'd1: begin a = 2'b10; b = 2'b10; end
      4'd2: begin a = 2'b01; b = 2'b10; end
      4'd3: begin mr = 1'b1; iord = 1'b1; end
      4'd4: begin rw = 1'b1; m2r = 1'b1; end
      4'd5: begin mw = 1'b1; iord = 1'b1; end
      4'd6: begin a = 2'b01; op = 2'b10; end
      4'd7: begin a = 2'b01; b = 2'b10; op = 2'b10; end
      4'd8: rw = 1'b1;
      4'd9: begin a = 2'b01; op = 2'b01; pcw_o = pcw; end
      default: ;
    endcase
    return {st, op, a, b, pcw_o, irw, mr, mw, rw, m2r, iord, ill, to};
  endfunction

  task automatic push(input logic [18:0] v, input string nm);
    exp_t e;
    e.v  = v;
    e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in a FETCH cycle, ends in the following FETCH cycle.
  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                       input logic l, input logic pcw, input string nm);
    logic ill;
    ill = !(op inside {OpLoad, OpStore, OpRType, OpIType, OpBranch});
    bus_if.opcode = op;
    bus_if.funct3 = f3;
    bus_if.zero   = z;
    bus_if.lt     = l;
    push(ev(4'd0, 1'b1, 1'b0, to_exp), {nm, " fetch"});
    tick();
    push(ev(4'd1, 1'b0, ill, to_exp), {nm, " decode"});
    case (op)
      OpLoad: begin
        tick(); push(ev(4'd2, 1'b0, 1'b0, to_exp), {nm, " memaddr"});
        tick(); push(ev(4'd3, 1'b0, 1'b0, to_exp), {nm, " memread"});
        tick(); push(ev(4'd4, 1'b0, 1'b0, to_exp), {nm, " memwb"});
      end
      OpStore: begin
        tick(); push(ev(4'd2, 1'b0, 1'b0, to_exp), {nm, " memaddr"});
        tick(); push(ev(4'd5, 1'b0, 1'b0, to_exp), {nm, " memwrite"});
      end
      OpRType: begin
        tick(); push(ev(4'd6, 1'b0, 1'b0, to_exp), {nm, " execr"});
        tick(); push(ev(4'd8, 1'b0, 1'b0, to_exp), {nm, " aluwb"});
      end
      OpIType: begin
        tick(); push(ev(4'd7, 1'b0, 1'b0, to_exp), {nm, " execi"});
        tick(); push(ev(4'd8, 1'b0, 1'b0, to_exp), {nm, " aluwb"});
      end
      OpBranch: begin
        tick(); push(ev(4'd9, pcw, 1'b0, to_exp), {nm, " branch"});
      end
      default: ;
    endcase
    tick();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [18:0] act;
      e   = exp_q.pop_front();
      act = {bus_if.state, bus_if.ALUOp, bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.PCWrite,
             bus_if.IRWrite, bus_if.MemRead, bus_if.MemWrite, bus_if.RegWrite,
             bus_if.MemtoReg, bus_if.IorD, bus_if.illegal, bus_if.timeout};
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s: got %b required %b", e.nm, act, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, queue=%0d", exp_q.size());
    $fatal(1);
  end

  initial begin
    total  = 0;
    bad    = 0;
    to_exp = 1'b0;
    reset  = 1'b1;
    bus_if.opcode    = 7'd0;
    bus_if.funct3    = 3'd0;
    bus_if.zero      = 1'b0;
    bus_if.lt        = 1'b0;
    bus_if.mem_ready = 1'b1;

    tick(); push(ResetVec, "reset hold a");
    tick(); push(ResetVec, "reset hold b");
    tick();
    reset = 1'b0;

    instr(OpLoad,   3'b000, 1'b0, 1'b0, 1'b0, "load");
    instr(OpStore,  3'b010, 1'b0, 1'b0, 1'b0, "store");
    instr(OpRType,  3'b000, 1'b0, 1'b0, 1'b0, "rtype");
    instr(OpIType,  3'b000, 1'b0, 1'b0, 1'b0, "itype");
    instr(OpBranch, 3'b100, 1'b0, 1'b1, 1'b1, "blt taken");
    instr(OpBranch, 3'b000, 1'b0, 1'b0, 1'b0, "beq not taken");
    instr(OpBranch, 3'b000, 1'b1, 1'b0, 1'b1, "beq taken");
    instr(OpBranch, 3'b001, 1'b1, 1'b1, 1'b0, "bne unsupported");
    instr(OpBranch, 3'b100, 1'b1, 1'b0, 1'b0, "blt not taken");
    instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, "illegal");

    // Reset asserted in the middle of EXEC_R
    bus_if.opcode = OpRType;
    push(ev(4'd0, 1'b1, 1'b0, 1'b0), "midrst fetch");
    tick(); push(ev(4'd1, 1'b0, 1'b0, 1'b0), "midrst decode");
    tick();
    #1 reset = 1'b1;
    push(ResetVec, "midrst async");
    tick();
    reset = 1'b0;
    instr(OpRType, 3'b000, 1'b0, 1'b0, 1'b0, "after midrst");

`ifdef MULTICYCLE_MEM_WAIT_EN
    bus_if.opcode    = OpIType;
    bus_if.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(ev(4'd0, 1'b0, 1'b0, 1'b0), "fetch wait");
      tick();
    end
    bus_if.mem_ready = 1'b1;
    push(ev(4'd0, 1'b1, 1'b0, 1'b0), "fetch ready");
    tick(); push(ev(4'd1, 1'b0, 1'b0, 1'b0), "wait decode");
    tick(); push(ev(4'd7, 1'b0, 1'b0, 1'b0), "wait execi");
    tick(); push(ev(4'd8, 1'b0, 1'b0, 1'b0), "wait aluwb");
    tick();

    bus_if.opcode = OpLoad;
    push(ev(4'd0, 1'b1, 1'b0, 1'b0), "to fetch");
    tick(); push(ev(4'd1, 1'b0, 1'b0, 1'b0), "to decode");
    tick(); push(ev(4'd2, 1'b0, 1'b0, 1'b0), "to memaddr");
    tick();
    bus_if.mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      push(ev(4'd3, 1'b0, 1'b0, 1'b0), "memread stall");
      tick();
    end
    bus_if.mem_ready = 1'b1;
    to_exp = 1'b1;
    instr(OpRType, 3'b000, 1'b0, 1'b0, 1'b0, "post timeout");
`else
    bus_if.mem_ready = 1'b0;
    instr(OpLoad,  3'b000, 1'b0, 1'b0, 1'b0, "load ready ignored");
    instr(OpStore, 3'b000, 1'b0, 1'b0, 1'b0, "store ready ignored");
`endif

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MAX_WAIT, default 15: memory-wait cycles tolerated before timeout (MEM_WAIT_EN builds only).
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  7  instruction[6:0] from instruction register.
REQ-005 funct3  in  3  instruction[14:12], branch condition select.
REQ-006 zero  in  1  ALU result==0 flag; lt  in  1  ALU signed less-than flag.
REQ-007 mem_ready  in  1  memory transfer complete (sampled only with MEM_WAIT_EN).
REQ-008 ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded, to ALU_Control.
REQ-009 ALUSrcA  out  2  00 PC, 01 rs1, 10 oldPC; ALUSrcB  out  2  00 rs2, 01 const 4, 10 imm.
REQ-010 PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg, IorD  out  1 each  datapath strobes/selects.
REQ-011 illegal  out  1  one-cycle pulse on unsupported opcode; timeout  out  1  sticky memory-timeout flag.
REQ-012 state  out  4  current state encoding, debug.

Function
REQ-013 States/encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9; codes 10-15 go to FETCH next cycle.
REQ-014 FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCWrite=1; -> DECODE.
REQ-015 DECODE: ALUSrcA=10, ALUSrcB=10, ALUOp=00 (branch target); opcode 0000011/0100011 -> MEM_ADDR, 0110011 -> EXEC_R, 0010011 -> EXEC_I, 1100011 -> BRANCH, other -> FETCH with illegal=1 that cycle.
REQ-016 MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=00; load -> MEM_READ, store -> MEM_WRITE.
REQ-017 MEM_READ: MemRead=1, IorD=1; -> MEM_WB. MEM_WB: RegWrite=1, MemtoReg=1; -> FETCH.
REQ-018 MEM_WRITE: MemWrite=1, IorD=1; -> FETCH.
REQ-019 EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=10; EXEC_I: same but ALUSrcB=10; both -> ALU_WB.
REQ-020 ALU_WB: RegWrite=1, MemtoReg=0; -> FETCH.
REQ-021 BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01; PCWrite=taken, taken=(funct3==000 & zero)|(funct3==100 & lt), other funct3 not taken; -> FETCH.
REQ-022 Outputs Moore-decoded from state register except BRANCH PCWrite (combinational on flags); unlisted outputs 0 in each state.
REQ-023 Instruction latency: load 5 cycles, store/R/I 4, branch 3 (no memory wait).

Reset
REQ-024 reset=1 forces state=FETCH, wait counter=0, timeout=0 immediately, independent of clk, including mid-instruction.
REQ-025 During reset all strobes except FETCH decode SHALL be 0: IRWrite, PCWrite, MemRead forced 0 while reset=1.
REQ-026 First FETCH actions occur on first rising clk edge after reset deasserts.

Configuration
REQ-027 Macro MULTICYCLE_MEM_WAIT_EN defined: FETCH, MEM_READ, MEM_WRITE hold (outputs stable, IRWrite/PCWrite asserted only in cycle mem_ready=1) until mem_ready=1; 4-bit wait counter counts held cycles, reaching MAX_WAIT sets timeout and forces FETCH next cycle.
REQ-028 Macro undefined: mem_ready ignored, each memory state lasts one cycle, timeout tied 0, no counter logic.

Verification
REQ-029 Reset mid-EXEC_R -> state=0 same cycle, outputs FETCH-decoded after release, timeout=0.
REQ-030 opcode=0000011 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-031 opcode=1100011, funct3=100, lt=1 -> PCWrite=1 in BRANCH; funct3=000, zero=0 -> PCWrite=0.
REQ-032 opcode=1111111 -> illegal=1 for one cycle in DECODE, next state FETCH.
REQ-033 MEM_WAIT_EN, mem_ready=0 for 3 cycles in FETCH -> state stays 0, IRWrite=0, then 1 on ready cycle; mem_ready stuck 0 for 15 cycles in MEM_READ -> timeout=1, state=0.
